// File: rtl/loa_eval_ctrl.sv
// ---------------------------------------------------------------------------
// loa_eval_ctrl
//
// Error-characterisation sequencer for a W-bit approximate adder. A 32-bit
// Galois LFSR produces operand triples. Each triple is registered onto the
// adder-under-test inputs, and the adder's combinational result is compared
// on the following cycle against an exactly computed sum. Four run figures
// are accumulated: vectors checked, erroneous vectors, saturating sum of
// absolute error, and vectors that meet the minimum-acceptable-accuracy
// bound.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        run request (sampled in IDLE only)
//   num_vec      vectors in the run (sampled with start)
//   seed         LFSR seed (sampled with start, 0 is replaced by 1)
//   add_a/add_b  registered operands to the adder under test
//   add_cin      registered carry-in to the adder under test
//   add_r        adder result {cout, sum}, combinational from add_a/b/cin
//   busy         high while vectors are being applied/checked
//   done         one-cycle pulse when a run completes
//   vec_cnt      vectors checked
//   err_cnt      vectors whose result differed from the exact sum
//   abs_err_sum  saturating sum of |exact - add_r|
//   ap_cnt       vectors meeting the accuracy bound
//
// Operands are sliced straight out of the LFSR word, so W must be <= 16.
// ---------------------------------------------------------------------------
module loa_eval_ctrl #(
    parameter int W       = 16,
    parameter int MAA_PCT = 90,
    parameter int CNT_W   = 32,
    parameter int SUM_W   = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [31:0]      seed,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    input  logic [W:0]       add_r,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] abs_err_sum,
    output logic [CNT_W-1:0] ap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_FIN
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // diff < 2^(W+1) and both multipliers are below 2^7, so W+8 bits hold
    // either product without loss.
    localparam int             PW      = W + 8;
    localparam logic [PW-1:0]  HUNDRED = PW'(100);
    localparam logic [PW-1:0]  MARGIN  = PW'(100 - MAA_PCT);

    // One spare bit above the wider of the accumulator and the addend so
    // that the overflow of a single add is always visible.
    localparam int               SW      = ((SUM_W > W + 1) ? SUM_W : W + 1) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_nxt;
    logic [CNT_W-1:0] num_vec_q;

    logic [W:0]       exact;
    logic [W:0]       diff;
    logic [PW-1:0]    err_scaled;
    logic [PW-1:0]    err_allowed;
    logic             ap_hit;
    logic [SW-1:0]    sum_ext;
    logic             sum_sat;
    logic [CNT_W-1:0] vec_inc;
    logic             last_vec;

    // -----------------------------------------------------------------------
    // Check datapath: exact reference and error metrics for the operands
    // currently presented to the adder.
    // -----------------------------------------------------------------------
    assign exact = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign diff  = (exact >= add_r) ? (exact - add_r) : (add_r - exact);

    // Accuracy test diff/exact < (100-MAA)/100, cross-multiplied to stay in
    // integers. A zero exact sum can only be accurate if it is hit exactly.
    assign err_scaled  = PW'(diff) * HUNDRED;
    assign err_allowed = PW'(exact) * MARGIN;
    assign ap_hit      = (err_scaled < err_allowed) ||
                         ((exact == '0) && (diff == '0));

    assign sum_ext = SW'(abs_err_sum) + SW'(diff);
    assign sum_sat = (sum_ext > SW'(SUM_MAX));

    assign vec_inc  = vec_cnt + CNT_W'(1);
    assign last_vec = (vec_inc == num_vec_q);

    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples the
            // pre-edge values, independent of process ordering.
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_vec == '0) ? S_FIN : S_APPLY;
                end
            end
            S_APPLY: begin
                busy      = 1'b1;
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy      = 1'b1;
                state_nxt = last_vec ? S_FIN : S_APPLY;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand generation and accumulation
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all datapath registers are reset, not just the FSM: the
            // operand and counter outputs must read 0 straight out of reset.
            lfsr        <= 32'h1;
            num_vec_q   <= '0;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            vec_cnt     <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            ap_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // An all-zero seed would lock the LFSR at zero.
                        lfsr        <= (seed == 32'h0) ? 32'h1 : seed;
                        num_vec_q   <= num_vec;
                        vec_cnt     <= '0;
                        err_cnt     <= '0;
                        abs_err_sum <= '0;
                        ap_cnt      <= '0;
                    end
                end
                S_APPLY: begin
                    add_a   <= lfsr[W-1:0];
                    add_b   <= lfsr[2*W-1:W];
                    add_cin <= lfsr[0] ^ lfsr[31];
                    lfsr    <= lfsr_nxt;
                end
                S_CHECK: begin
                    vec_cnt <= vec_inc;
                    if (diff != '0) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    if (ap_hit) begin
                        ap_cnt <= ap_cnt + CNT_W'(1);
                    end
                    abs_err_sum <= sum_sat ? SUM_MAX : sum_ext[SUM_W-1:0];
                end
                default: begin
                    // FIN: everything holds for the idle period.
                end
            endcase
        end
    end

endmodule
